// File: rtl/fifo_rr_reader.sv
// fifo_rr_reader: drains four upstream FIFOs round-robin with bounded bursts
// and forwards each popped word to one downstream FIFO one cycle later.
module fifo_rr_reader #(
    parameter int DATA_SIZE = 10,
    parameter int NUM_Q     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_Q-1:0]           fifo_empty,
    input  logic [NUM_Q*DATA_SIZE-1:0] data_out_pop,
    output logic [NUM_Q-1:0]           read,
    input  logic                       fifo_pause,
    input  logic                       Fifo_full,
    output logic                       write,
    output logic [DATA_SIZE-1:0]       data_in_push,
    output logic [1:0]                 active_q,
    output logic                       busy,
    output logic                       overflow_error,
    output logic [7:0]                 words_out
);
    typedef enum logic {IDLE, POP} state_t;
    localparam logic [3:0] BMAX  = 4'(BURST_MAX);
    localparam logic [3:0] BLAST = 4'(BURST_MAX - 1);

    state_t     state_q;
    logic [3:0] burst_cnt_q;
    logic [1:0] last_grant_q, grant_q, active_d, idx;
    logic       rd_q, pop_en, last_word;

    // Lowest offset from last_grant wins, so scan offsets from farthest to nearest.
    always_comb begin
        active_d = last_grant_q;
        idx      = last_grant_q;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant_q + 2'(k);
            if (!fifo_empty[idx]) active_d = idx;
        end
    end

    assign pop_en       = state_q == POP && !fifo_empty[active_q] && !fifo_pause && burst_cnt_q < BMAX;
    assign last_word    = pop_en && burst_cnt_q == BLAST;
    assign read         = pop_en ? NUM_Q'(1) << active_q : '0;
    assign write        = rd_q;
    assign data_in_push = rd_q ? data_out_pop[grant_q*DATA_SIZE +: DATA_SIZE] : '0;
    assign busy         = state_q == POP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            burst_cnt_q    <= '0;
            last_grant_q   <= 2'd3;
            active_q       <= '0;
            rd_q           <= 1'b0;
            grant_q        <= '0;
            overflow_error <= 1'b0;
            words_out      <= '0;
        end else begin
            rd_q    <= pop_en;
            grant_q <= active_q;
            if (rd_q) words_out <= words_out + 8'd1;
            if (rd_q && Fifo_full) overflow_error <= 1'b1;
            if (state_q == IDLE) begin
                if (!fifo_pause && !(&fifo_empty)) begin
                    active_q    <= active_d;
                    burst_cnt_q <= '0;
                    state_q     <= POP;
                end
            end else begin
                if (pop_en) burst_cnt_q <= burst_cnt_q + 4'd1;
                if (!pop_en || last_word) begin
                    state_q <= IDLE;
                    // A grant that never popped keeps its place at the head of the search.
                    if (pop_en || burst_cnt_q != '0) last_grant_q <= active_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_reader.sv
// tb_fifo_rr_reader: directed and randomized checks of fifo_rr_reader against a
// queue-based upstream FIFO model and a round-robin burst reference.
module tb_fifo_rr_reader;
    localparam int DW = 10, NQ = 4, BM = 4;

    logic              clk = 1'b0, reset = 1'b1, fifo_pause = 1'b0, Fifo_full = 1'b0;
    logic [NQ-1:0]     fifo_empty = '1;
    logic [NQ*DW-1:0]  data_out_pop = '0;
    logic [NQ-1:0]     read;
    logic              write, busy, overflow_error;
    logic [DW-1:0]     data_in_push;
    logic [1:0]        active_q;
    logic [7:0]        words_out;

    int                n_chk = 0, n_fail = 0;
    logic [DW-1:0]     upq[NQ][$];
    logic [DW-1:0]     refq[NQ][$];
    int                obs_q[$], obs_n[$], exp_q[$], exp_n[$];
    logic              pend_v = 1'b0, exp_ovf = 1'b0;
    logic [DW-1:0]     pend_d = '0;
    logic [7:0]        exp_words = '0;
    logic [NQ-1:0]     rd_s = '0, run_oh = '0;
    int                run_len = 0;

    fifo_rr_reader #(.DATA_SIZE(DW), .NUM_Q(NQ), .BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .data_out_pop(data_out_pop),
        .read(read), .fifo_pause(fifo_pause), .Fifo_full(Fifo_full), .write(write),
        .data_in_push(data_in_push), .active_q(active_q), .busy(busy),
        .overflow_error(overflow_error), .words_out(words_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [NQ-1:0] oh);
        for (int i = 0; i < NQ; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic update_empty();
        for (int i = 0; i < NQ; i++) fifo_empty[i] = upq[i].size() == 0;
    endtask

    task automatic load(input int q, input logic [DW-1:0] w);
        upq[q].push_back(w);
        refq[q].push_back(w);
        update_empty();
    endtask

    task automatic flush_run();
        if (run_len > 0) begin
            obs_q.push_back(oh2i(run_oh));
            obs_n.push_back(run_len);
        end
        run_len = 0;
    endtask

    // Observe at the falling edge, then let the upstream model pop just after the rising edge.
    task automatic tick();
        int i;
        @(negedge clk);
        if (!reset) begin
            chk("rst_read", read, 0);
            chk("rst_write", write, 0);
            chk("rst_data", data_in_push, 0);
            chk("rst_busy", busy, 0);
            chk("rst_active", active_q, 0);
            chk("rst_words", words_out, 0);
            chk("rst_ovf", overflow_error, 0);
            pend_v = 1'b0; exp_words = '0; exp_ovf = 1'b0; run_len = 0;
        end else begin
            chk("write", write, pend_v);
            chk("data", data_in_push, pend_v ? pend_d : '0);
            chk("words_out", words_out, exp_words);
            chk("overflow", overflow_error, exp_ovf);
            if (pend_v) begin
                exp_words += 8'd1;
                exp_ovf |= Fifo_full;
            end
            pend_v = |read;
            if (pend_v) begin
                i = oh2i(read);
                chk("read_onehot", $countones(read), 1);
                chk("read_legal", {fifo_pause, fifo_empty[i]}, 0);
                chk("busy_read", busy, 1);
                chk("active_read", active_q, i);
                if (refq[i].size() > 0) pend_d = refq[i].pop_front();
                else pend_d = 'x;
            end
            if (read == '0 || read != run_oh) flush_run();
            if (read != '0) begin
                run_oh = read;
                run_len++;
            end
        end
        rd_s = read;
        @(posedge clk);
        #1;
        for (int k = 0; k < NQ; k++)
            if (rd_s[k] && upq[k].size() > 0) data_out_pop[k*DW +: DW] = upq[k].pop_front();
        update_empty();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fifo_pause = 1'b0;
        Fifo_full = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            upq[i].delete();
            refq[i].delete();
        end
        update_empty();
        tick();
        tick();
        obs_q.delete(); obs_n.delete();
    endtask

    task automatic drain(input int budget, input bit rnd_full);
        for (int k = 0; k < budget; k++) begin
            if (rnd_full) Fifo_full = $urandom_range(0, 3) == 0;
            tick();
            if (fifo_empty == '1 && rd_s == '0 && !pend_v && !busy) break;
        end
        Fifo_full = 1'b0;
        tick();
        tick();
    endtask

    // Reference: grant the next non-empty queue after the last one served, take up to BM words.
    task automatic rr_model(input int c[NQ]);
        int last, j, n, tot;
        last = NQ - 1;
        exp_q.delete(); exp_n.delete();
        tot = 0;
        for (int i = 0; i < NQ; i++) tot += c[i];
        while (tot > 0) begin
            j = 0;
            for (int k = 1; k <= NQ; k++) begin
                j = (last + k) % NQ;
                if (c[j] > 0) break;
            end
            n = c[j] < BM ? c[j] : BM;
            exp_q.push_back(j);
            exp_n.push_back(n);
            c[j] -= n;
            tot -= n;
            last = j;
        end
    endtask

    task automatic compare_bursts(input string tag);
        int m;
        chk({tag, "_nbursts"}, obs_q.size(), exp_q.size());
        m = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) begin
            chk({tag, "_burst_q"}, obs_q[k], exp_q[k]);
            chk({tag, "_burst_len"}, obs_n[k], exp_n[k]);
        end
    endtask

    initial begin
        int c[NQ];
        int tot;
        #2 reset = 1'b0;
        // Reset with every queue holding data
        for (int i = 0; i < NQ; i++) begin
            load(i, DW'(16 + i));
            load(i, DW'(32 + i));
        end
        repeat (3) tick();

        // Single queue
        do_reset();
        load(0, 10'h101); load(0, 10'h102); load(0, 10'h103);
        reset = 1'b1;
        tick();
        chk("sq_first_idle", rd_s, 0);
        repeat (3) begin
            tick();
            chk("sq_read", rd_s, 4'b0001);
        end
        tick();
        chk("sq_stop", rd_s, 0);
        tick();
        chk("sq_words", words_out, 3);
        chk("sq_busy", busy, 0);

        // Round-robin, six words per queue
        do_reset();
        for (int i = 0; i < NQ; i++)
            for (int k = 0; k < 6; k++) load(i, DW'((i << 8) | (k + 1)));
        reset = 1'b1;
        drain(200, 1'b0);
        c = '{6, 6, 6, 6};
        rr_model(c);
        compare_bursts("rr");
        chk("rr_words", words_out, 24);

        // Pause mid-burst on q1, then pause before the first pop of q2
        do_reset();
        load(0, 10'h011);
        for (int k = 0; k < 4; k++) load(1, DW'(10'h120 + k));
        for (int k = 0; k < 3; k++) load(2, DW'(10'h230 + k));
        reset = 1'b1;
        for (int k = 0; k < 20 && rd_s != 4'b0010; k++) tick();
        chk("p1_grant_q1", rd_s, 4'b0010);
        tick();
        chk("p1_second_pop", rd_s, 4'b0010);
        fifo_pause = 1'b1;
        #1 chk("p1_read_drop", read, 0);
        repeat (4) tick();
        chk("p1_words", words_out, 3);
        fifo_pause = 1'b0;
        tick();
        chk("p2_arb_idle", rd_s, 0);
        fifo_pause = 1'b1;
        tick();
        chk("p1_grant_q2", active_q, 2);
        chk("p2_no_pop", rd_s, 0);
        repeat (2) tick();
        fifo_pause = 1'b0;
        for (int k = 0; k < 10 && rd_s == '0; k++) tick();
        chk("p2_regrant_q2", rd_s, 4'b0100);
        drain(100, 1'b0);
        chk("p_words", words_out, 8);

        // Overflow: downstream full during one write
        do_reset();
        load(3, 10'h3a1); load(3, 10'h3a2);
        reset = 1'b1;
        for (int k = 0; k < 10 && rd_s != 4'b1000; k++) tick();
        chk("ovf_grant_q3", rd_s, 4'b1000);
        Fifo_full = 1'b1;
        tick();
        Fifo_full = 1'b0;
        repeat (2) tick();
        chk("ovf_set", overflow_error, 1);
        drain(20, 1'b0);
        chk("ovf_sticky", overflow_error, 1);
        reset = 1'b0;
        #1 chk("ovf_clear", overflow_error, 0);
        tick();

        // Reset in the middle of a q2 burst
        do_reset();
        for (int k = 0; k < 6; k++) load(0, DW'(10'h300 + k));
        for (int k = 0; k < 4; k++) load(2, DW'(10'h2c0 + k));
        reset = 1'b1;
        for (int k = 0; k < 30 && rd_s != 4'b0100; k++) tick();
        chk("mr_grant_q2", rd_s, 4'b0100);
        chk("mr_pre_read", read, 4'b0100);
        reset = 1'b0;
        #1;
        chk("mr_read", read, 0);
        chk("mr_write", write, 0);
        chk("mr_data", data_in_push, 0);
        chk("mr_busy", busy, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10 && rd_s == '0; k++) tick();
        chk("mr_next_q0", rd_s, 4'b0001);
        drain(60, 1'b0);

        // Randomized loads and downstream-full pattern
        repeat (6) begin
            do_reset();
            tot = 0;
            for (int i = 0; i < NQ; i++) begin
                c[i] = $urandom_range(0, 9);
                tot += c[i];
                for (int k = 0; k < c[i]; k++) load(i, DW'($urandom));
            end
            reset = 1'b1;
            drain(300, 1'b1);
            rr_model(c);
            compare_bursts("rnd");
            chk("rnd_words", words_out, tot);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
